echo_divider: RTL and testbench
===============================

# echo_divider

Parametrised sequential unsigned divider for the ultrasonic ranging path. It converts a captured echo pulse-width count into distance units, `distance = count / divisor`, with a runtime divisor and optional round-to-nearest. It sits between the echo-width counter and the distance display/comparator logic. A start/busy/done handshake replaces the fixed shift-by-one combinational divide used previously.

## Interface

Parameters:
- `WIDTH`, default 16: dividend, quotient and remainder width.
- `DWIDTH`, default 8: divisor width; must satisfy `DWIDTH <= WIDTH`.
- `ROUND`, default 0: 0 = truncate; 1 = round quotient to nearest, ties rounded up.

Ports:
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `reset`, in, 1: **synchronous, active-low reset**.
- `start`, in, 1: single-cycle request; samples `count` and `divisor`.
- `count`, in, WIDTH: dividend (echo width in clock ticks).
- `divisor`, in, DWIDTH: ticks per distance unit.
- `busy`, out, 1: high while a division is iterating.
- `done`, out, 1: one-cycle pulse; results valid from this cycle.
- `quotient`, out, WIDTH: result, held until the next `done`.
- `remainder`, out, WIDTH: remainder; zero-extended from DWIDTH significant bits.
- `div_zero`, out, 1: set with `done` when the divisor was 0; held with the results.

## Operation

- FSM states: `IDLE`, `RUN`, `FIN`.
- **IDLE**, or FIN with `start=1`:
  - Latch `count` into the dividend shift register.
  - Latch `divisor` zero-extended to WIDTH+1 bits.
  - Clear the partial remainder; load the iteration counter with WIDTH-1.
  - If `divisor==0`, go to FIN directly. Otherwise go to RUN.
- **RUN**: restoring radix-2 step each cycle, one quotient bit per cycle, MSB first.
  - Shift `{rem, dividend}` left by 1.
  - Trial subtract: `rem - divisor`, WIDTH+1 bits.
  - If the result is non-negative, keep the difference and shift in 1. Otherwise keep `rem` and shift in 0.
  - Counter decrements each step; on the step where counter==0, go to FIN.
- **FIN**: present registered results.
  - `done=1` for exactly one cycle, then return to IDLE unless `start` is high.
  - With ROUND=1: if `2*rem >= divisor`, quotient +1. No overflow is possible: divisor=1 gives rem=0, and divisor>=2 gives q <= max/2.
  - Divide-by-zero: `quotient` = all ones, `remainder` = `count`, `div_zero=1`. No RUN cycles.
- `start` while in RUN is ignored. No queuing, no restart.
- `quotient`, `remainder` and `div_zero` change only in the cycle `done` is asserted. Otherwise they hold.
- Reset (`reset==0` at a clock edge) overrides everything, including mid-RUN. The operation is aborted and its result is never delivered.

## Timing

- Reset values: state IDLE, `busy=0`, `done=0`, `quotient=0`, `remainder=0`, `div_zero=0`.
- `start` sampled at edge E gives:
  - `busy` high from E+1 through E+WIDTH.
  - Results and `done` registered at E+WIDTH+1.
  - Latency is WIDTH+1 cycles: 17 for the default configuration.
- Divide-by-zero: `done` at E+1; `busy` never asserted.
- Back-to-back operation: `start` asserted in the `done` cycle is accepted. Throughput is one result per WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from `start`, `count` or `divisor` to any output.
- `count` and `divisor` need only be valid in the `start` cycle.

## Structure

- Package `ultra_pkg`:
  - State enum `div_state_t` with IDLE, RUN, FIN.
  - Shared constant `CYCLES_PER_CM`, used by the integration to drive `divisor`.
- One natural sub-module, `div_step`: combinational shift/trial-subtract/select for one restoring iteration, parametrised on WIDTH.
- The iteration counter is `$clog2(WIDTH)` bits wide.

## Test plan

1. Defaults: `count=100`, `divisor=2`, start → `done` 17 cycles later, `quotient=50`, `remainder=0`, `div_zero=0`.
2. ROUND=0: `count=1000`, `divisor=7` → `quotient=142`, `remainder=6`. ROUND=1 instance, same inputs → `quotient=143`. ROUND=1 tie case: `count=15`, `divisor=2` → 8.
3. `divisor=0`, `count=1234` → `done` one cycle after start, `quotient=16'hFFFF`, `remainder=1234`, `div_zero=1`. The next valid division clears `div_zero`.
4. `start` pulsed again 5 cycles into RUN with different operands → ignored. The first result (`65535/1=65535`, rem 0) is delivered at the original cycle.
5. `reset` low for one cycle mid-RUN → next cycle all outputs 0, state IDLE, no `done`. A subsequent `count=58`, `divisor=58` gives `quotient=1`.
6. `start` held high continuously with `count=300`, `divisor=3` → `done` every 17 cycles, `quotient=100` each time; outputs stable between pulses.

Source files
------------

// File: rtl/ultra_pkg.sv
// ultra_pkg: shared types and constants for the ultrasonic ranging path
package ultra_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} div_state_t;
    localparam int CYCLES_PER_CM = 58;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring radix-2 iteration (shift, trial subtract, select)
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH:0]   dsr,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] dvd_nxt
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    assign sh      = {rem, dvd[WIDTH-1]};
    assign diff    = sh - dsr;
    // rem < divisor keeps the shifted value below 2*divisor, so diff[WIDTH] is an exact sign bit
    assign rem_nxt = diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/echo_divider.sv
// echo_divider: sequential unsigned divider turning echo width counts into distance units
module echo_divider
    import ultra_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DWIDTH = 8,
    parameter int ROUND  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  count,
    input  logic [DWIDTH-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  quotient,
    output logic [WIDTH-1:0]  remainder,
    output logic              div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    div_state_t       state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH:0]   dsr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dvd_nxt;
    logic [WIDTH-1:0] q_fin;
    logic             rnd;
    logic             load;
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .dvd     (dvd),
        .dsr     (dsr),
        .rem_nxt (rem_nxt),
        .dvd_nxt (dvd_nxt)
    );
    assign load  = start && (state != RUN);
    assign rnd   = (ROUND != 0) && ({rem_nxt, 1'b0} >= dsr);
    assign q_fin = dvd_nxt + {{(WIDTH-1){1'b0}}, rnd};
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            dvd       <= '0;
            rem       <= '0;
            dsr       <= '0;
            cnt       <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                dvd <= count;
                dsr <= {{(WIDTH+1-DWIDTH){1'b0}}, divisor};
                rem <= '0;
                cnt <= CW'(WIDTH-1);
                if (divisor == '0) begin
                    state     <= FIN;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= '1;
                    remainder <= count;
                    div_zero  <= 1'b1;
                end else begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
            end else if (state == RUN) begin
                dvd <= dvd_nxt;
                rem <= rem_nxt;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    state     <= FIN;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= q_fin;
                    remainder <= rem_nxt;
                    div_zero  <= 1'b0;
                end
            end else if (state == FIN) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_echo_divider.sv
// tb_echo_divider: randomized and directed checks of echo_divider against a timeline model
module tb_echo_divider;
    import ultra_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] count = '0;
    logic [7:0]  divisor = '0;
    logic        busy0, done0, dz0, busy1, done1, dz1;
    logic [15:0] q0, r0, q1, r1;
    int          vectors = 0;
    int          miscompares = 0;
    echo_divider #(.WIDTH(16), .DWIDTH(8), .ROUND(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .count(count), .divisor(divisor),
        .busy(busy0), .done(done0), .quotient(q0), .remainder(r0), .div_zero(dz0)
    );
    echo_divider #(.WIDTH(16), .DWIDTH(8), .ROUND(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .count(count), .divisor(divisor),
        .busy(busy1), .done(done1), .quotient(q1), .remainder(r1), .div_zero(dz1)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask
    // Model: an accepted op delivers its arithmetic result 16 edges later; start is ignored while one is pending
    bit mvalid = 1'b0, pending = 1'b0, acc, mdz, mdone, mbusy;
    int t = 0, due = 0, mq0, mq1, mr, pq0, pq1, pr;
    always @(posedge clk) begin
        t++;
        mvalid = 1'b1;
        if (!reset) begin
            pending = 1'b0; mbusy = 1'b0; mdone = 1'b0;
            mq0 = 0; mq1 = 0; mr = 0; mdz = 1'b0;
        end else begin
            acc = start && !pending;
            mdone = 1'b0;
            if (pending && t == due) begin
                mq0 = pq0; mq1 = pq1; mr = pr; mdz = 1'b0; mdone = 1'b1; pending = 1'b0;
            end
            if (acc) begin
                if (divisor == 8'd0) begin
                    mq0 = 65535; mq1 = 65535; mr = int'(count); mdz = 1'b1; mdone = 1'b1;
                end else begin
                    pq0 = int'(count) / int'(divisor);
                    pr  = int'(count) % int'(divisor);
                    pq1 = pq0 + ((2 * pr >= int'(divisor)) ? 1 : 0);
                    pending = 1'b1;
                    due = t + 16;
                end
            end
            mbusy = pending;
        end
    end
    always @(negedge clk) begin
        if (mvalid) begin
            chk("busy_t", 64'(busy0), 64'(mbusy));
            chk("done_t", 64'(done0), 64'(mdone));
            chk("quot_t", 64'(q0), 64'(mq0));
            chk("rem_t", 64'(r0), 64'(mr));
            chk("dz_t", 64'(dz0), 64'(mdz));
            chk("busy_r", 64'(busy1), 64'(mbusy));
            chk("done_r", 64'(done1), 64'(mdone));
            chk("quot_r", 64'(q1), 64'(mq1));
            chk("rem_r", 64'(r1), 64'(mr));
            chk("dz_r", 64'(dz1), 64'(mdz));
        end
    end
    task automatic do_op(input logic [15:0] c, input logic [7:0] d, input int lat,
                         input int eq0, input int eq1, input int er, input bit edz);
        int n;
        @(negedge clk);
        count = c; divisor = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (done0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("op_latency", 64'(n), 64'(lat));
        chk("op_quot_trunc", 64'(q0), 64'(eq0));
        chk("op_quot_round", 64'(q1), 64'(eq1));
        chk("op_rem", 64'(r0), 64'(er));
        chk("op_div_zero", 64'(dz0), 64'(edz));
    endtask
    initial begin
        int n, nd;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_quot", 64'(q0), 64'd0);
        chk("rst_rem", 64'(r0), 64'd0);
        chk("rst_dz", 64'(dz0), 64'd0);
        reset = 1'b1;
        do_op(16'd100, 8'd2, 17, 50, 50, 0, 1'b0);
        do_op(16'd1000, 8'd7, 17, 142, 143, 6, 1'b0);
        do_op(16'd15, 8'd2, 17, 7, 8, 1, 1'b0);
        do_op(16'd1234, 8'd0, 1, 65535, 65535, 1234, 1'b1);
        do_op(16'd1000, 8'd7, 17, 142, 143, 6, 1'b0);
        @(negedge clk);
        count = 16'hFFFF; divisor = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        count = 16'd10; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
        while (done0 !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ign_latency", 64'(n), 64'd17);
        chk("ign_quot", 64'(q0), 64'd65535);
        chk("ign_quot_round", 64'(q1), 64'd65535);
        chk("ign_rem", 64'(r0), 64'd0);
        repeat (20) @(negedge clk);
        count = 16'd500; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_quot", 64'(q0), 64'd0);
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 === 1'b1) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        do_op(16'd58, 8'(CYCLES_PER_CM), 17, 1, 1, 0, 1'b0);
        @(negedge clk);
        count = 16'd300; divisor = 8'd3; start = 1'b1;
        nd = 0;
        for (int i = 1; i <= 51; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                nd++;
                chk("b2b_phase", 64'(i % 17), 64'd0);
                chk("b2b_quot", 64'(q0), 64'd100);
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(nd), 64'd3);
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset   = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 4) == 0);
            count   = 16'($urandom);
            divisor = ($urandom_range(0, 9) == 0) ? 8'd0 :
                      ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(1, 4));
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
